// File: rtl/pampy_arb_pkg.sv
// Shared types and constants for the pamPy data-memory port arbiter.
// Includes the FSM state encoding, owner codes and parameter range limits.
package pampy_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 7;
    localparam int MAX_WAIT_MIN   = 1;
    localparam int MAX_WAIT_MAX   = 15;

    function automatic bit in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between core and host requests.
// PAMPY_ARB_ROUND_ROBIN_EN selects alternating ties; otherwise core priority with a starvation guard.
module arb_pick
    import pampy_arb_pkg::*;
`ifndef PAMPY_ARB_ROUND_ROBIN_EN
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
)
`endif
(
    input  logic             core_req,
    input  logic             host_req,
`ifdef PAMPY_ARB_ROUND_ROBIN_EN
    input  logic             last_owner,
`else
    input  logic [CNT_W-1:0] starve_cnt,
`endif
    output logic             grant_vld,
    output logic             grant_owner
);

    always_comb begin
        grant_vld   = core_req | host_req;
        grant_owner = OWNER_CORE;
        if (host_req && !core_req) begin
            grant_owner = OWNER_HOST;
        end else if (host_req && core_req) begin
`ifdef PAMPY_ARB_ROUND_ROBIN_EN
            grant_owner = (last_owner == OWNER_CORE) ? OWNER_HOST : OWNER_CORE;
`else
            // Host has waited out MAX_WAIT core grants: it takes this tie.
            grant_owner = (starve_cnt == CNT_W'(MAX_WAIT)) ? OWNER_HOST : OWNER_CORE;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-RAM port between the pamPy core and the host/debug port.
// Build option: PAMPY_ARB_ROUND_ROBIN_EN (round-robin ties instead of starvation-guarded core priority).
module mem_port_arbiter
    import pampy_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  general_clk,
    input  logic                  general_reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_done,
    output logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_done,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    if (!in_range(RD_LATENCY, RD_LATENCY_MIN, RD_LATENCY_MAX)) begin : g_bad_rd_latency
        $error("mem_port_arbiter: RD_LATENCY must be 1..7");
    end
    if (!in_range(MAX_WAIT, MAX_WAIT_MIN, MAX_WAIT_MAX)) begin : g_bad_max_wait
        $error("mem_port_arbiter: MAX_WAIT must be 1..15");
    end

    // WAIT spends RD_LATENCY-1 cycles; counter is loaded with that minus one.
    localparam logic [2:0] LAT_LOAD = (RD_LATENCY > 1) ? 3'(RD_LATENCY - 2) : 3'd0;

    arb_state_e            state_q, state_d;
    logic                  owner_q, we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [2:0]            lat_q;
    logic [DATA_WIDTH-1:0] core_rdata_q, host_rdata_q;
    logic                  grant_vld, grant_owner;
    logic                  take, issue, resp, core_cap, host_cap;

`ifdef PAMPY_ARB_ROUND_ROBIN_EN
    logic last_owner_q;
`else
    localparam int CNT_W = 4;
    logic [CNT_W-1:0] starve_q;
`endif

    arb_pick
`ifndef PAMPY_ARB_ROUND_ROBIN_EN
        #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W))
`endif
    u_pick (
        .core_req    (core_req),
        .host_req    (host_req),
`ifdef PAMPY_ARB_ROUND_ROBIN_EN
        .last_owner  (last_owner_q),
`else
        .starve_cnt  (starve_q),
`endif
        .grant_vld   (grant_vld),
        .grant_owner (grant_owner)
    );

    assign take  = (state_q == IDLE) && grant_vld;
    assign issue = (state_q == ISSUE);
    assign resp  = (state_q == RESP);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = ISSUE;
            ISSUE:   state_d = (we_q || RD_LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (lat_q == 3'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge general_clk or posedge general_reset) begin
        if (general_reset) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_CORE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lat_q        <= 3'd0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                owner_q <= grant_owner;
                we_q    <= (grant_owner == OWNER_HOST) ? host_we    : core_we;
                addr_q  <= (grant_owner == OWNER_HOST) ? host_addr  : core_addr;
                wdata_q <= (grant_owner == OWNER_HOST) ? host_wdata : core_wdata;
            end
            if (issue) begin
                lat_q <= LAT_LOAD;
            end else if (state_q == WAIT && lat_q != 3'd0) begin
                lat_q <= lat_q - 3'd1;
            end
            if (core_cap) core_rdata_q <= mem_rdata;
            if (host_cap) host_rdata_q <= mem_rdata;
        end
    end

`ifdef PAMPY_ARB_ROUND_ROBIN_EN
    always_ff @(posedge general_clk or posedge general_reset) begin
        if (general_reset) begin
            last_owner_q <= OWNER_HOST;
        end else if (take) begin
            last_owner_q <= grant_owner;
        end
    end
`else
    always_ff @(posedge general_clk or posedge general_reset) begin
        if (general_reset) begin
            starve_q <= '0;
        end else if (take) begin
            if (grant_owner == OWNER_HOST) begin
                starve_q <= '0;
            end else if (host_req && starve_q != CNT_W'(MAX_WAIT)) begin
                starve_q <= starve_q + CNT_W'(1);
            end
        end
    end
`endif

    // Read data is forwarded combinationally in RESP so it is valid alongside done.
    assign core_cap   = resp && !we_q && (owner_q == OWNER_CORE);
    assign host_cap   = resp && !we_q && (owner_q == OWNER_HOST);
    assign core_rdata = core_cap ? mem_rdata : core_rdata_q;
    assign host_rdata = host_cap ? mem_rdata : host_rdata_q;
    assign core_done  = resp && (owner_q == OWNER_CORE);
    assign host_done  = resp && (owner_q == OWNER_HOST);

    assign mem_en    = issue;
    assign mem_we    = issue & we_q;
    assign mem_addr  = issue ? addr_q  : '0;
    assign mem_wdata = issue ? wdata_q : '0;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance A with RD_LATENCY=1, instance B with RD_LATENCY=3.
// Honours PAMPY_ARB_ROUND_ROBIN_EN for the expected grant order.
module tb_mem_port_arbiter;
    import pampy_arb_pkg::*;

    localparam int DW = 8;
    localparam int AW = 12;

    typedef struct {
        logic          owner;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sbq[$];
    logic ownq[$];
    int   vectors    = 0;
    int   miscompares = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          a_core_req, a_core_we, a_core_done, a_host_req, a_host_we, a_host_done;
    logic [AW-1:0] a_core_addr, a_host_addr, a_mem_addr;
    logic [DW-1:0] a_core_wdata, a_core_rdata, a_host_wdata, a_host_rdata;
    logic          a_mem_en, a_mem_we, a_busy;
    logic [DW-1:0] a_mem_wdata, a_mem_rdata;

    logic          b_core_req, b_core_we, b_core_done, b_host_req, b_host_we, b_host_done;
    logic [AW-1:0] b_core_addr, b_host_addr, b_mem_addr;
    logic [DW-1:0] b_core_wdata, b_core_rdata, b_host_wdata, b_host_rdata;
    logic          b_mem_en, b_mem_we, b_busy;
    logic [DW-1:0] b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .MAX_WAIT(4)) dut_a (
        .general_clk(clk), .general_reset(rst),
        .core_req(a_core_req), .core_we(a_core_we), .core_addr(a_core_addr), .core_wdata(a_core_wdata),
        .core_done(a_core_done), .core_rdata(a_core_rdata),
        .host_req(a_host_req), .host_we(a_host_we), .host_addr(a_host_addr), .host_wdata(a_host_wdata),
        .host_done(a_host_done), .host_rdata(a_host_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy));

    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3), .MAX_WAIT(4)) dut_b (
        .general_clk(clk), .general_reset(rst),
        .core_req(b_core_req), .core_we(b_core_we), .core_addr(b_core_addr), .core_wdata(b_core_wdata),
        .core_done(b_core_done), .core_rdata(b_core_rdata),
        .host_req(b_host_req), .host_we(b_host_we), .host_addr(b_host_addr), .host_wdata(b_host_wdata),
        .host_done(b_host_done), .host_rdata(b_host_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy));

    // RAM models: A has 1-cycle read latency, B has 3.
    logic          pre_a_we, pre_b_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] mem_a [0:4095];
    logic [DW-1:0] mem_b [0:4095];
    logic [DW-1:0] b_pipe [0:2];

    always @(posedge clk) begin
        if (pre_a_we) mem_a[pre_addr] <= pre_data;
        if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
        if (a_mem_en && !a_mem_we) a_mem_rdata <= mem_a[a_mem_addr];
    end

    always @(posedge clk) begin
        if (pre_b_we) mem_b[pre_addr] <= pre_data;
        if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
        b_pipe[0] <= mem_b[b_mem_addr];
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_mem_rdata = b_pipe[2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input bit to_b, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        pre_addr = addr;
        pre_data = data;
        if (to_b) pre_b_we = 1'b1; else pre_a_we = 1'b1;
        tick();
        pre_a_we = 1'b0;
        pre_b_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        {a_core_req, a_core_we, a_host_req, a_host_we} = '0;
        {b_core_req, b_core_we, b_host_req, b_host_we} = '0;
        {a_core_addr, a_host_addr, b_core_addr, b_host_addr} = '0;
        {a_core_wdata, a_host_wdata, b_core_wdata, b_host_wdata} = '0;
        {pre_a_we, pre_b_we, pre_addr, pre_data} = '0;
        a_mem_rdata = '0;
        tick();
        tick();
        vectors++;
        if ({a_busy, a_mem_en, a_mem_we, a_core_done, a_host_done} !== 5'b0)
            begin miscompares++; $display("FAIL reset_ctrl_a: got %b want 00000", {a_busy, a_mem_en, a_mem_we, a_core_done, a_host_done}); end
        vectors++;
        if ({a_mem_addr, a_mem_wdata, a_core_rdata, a_host_rdata} !== '0)
            begin miscompares++; $display("FAIL reset_data_a: got addr=%h wd=%h crd=%h hrd=%h want 0", a_mem_addr, a_mem_wdata, a_core_rdata, a_host_rdata); end
        vectors++;
        if ({b_busy, b_mem_en, b_core_done, b_host_done} !== 4'b0)
            begin miscompares++; $display("FAIL reset_ctrl_b: got %b want 0000", {b_busy, b_mem_en, b_core_done, b_host_done}); end
        rst = 1'b0;
        tick();
        vectors++;
        if (a_busy !== 1'b0 || a_mem_en !== 1'b0)
            begin miscompares++; $display("FAIL reset_release: busy=%b mem_en=%b want 0 0", a_busy, a_mem_en); end
    endtask

    task automatic test_core_read();
        exp_t e;
        preload(1'b0, 12'h010, 8'hA5);
        a_core_we = 1'b0; a_core_addr = 12'h010; a_core_req = 1'b1;
        sbq.push_back('{OWNER_CORE, 8'hA5});
        vectors++;
        if (a_mem_en !== 1'b0)
            begin miscompares++; $display("FAIL t1_req_cycle: mem_en=%b want 0", a_mem_en); end
        tick();
        vectors++;
        if (a_mem_en !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 12'h010 || a_core_done !== 1'b0)
            begin miscompares++; $display("FAIL t1_issue: en=%b we=%b addr=%h done=%b want 1 0 010 0", a_mem_en, a_mem_we, a_mem_addr, a_core_done); end
        tick();
        e = sbq.pop_front();
        vectors++;
        if (a_core_done !== 1'b1 || a_host_done !== 1'b0 || a_core_rdata !== e.rdata)
            begin miscompares++; $display("FAIL t1_done: cdone=%b hdone=%b rdata=%h want 1 0 %h", a_core_done, a_host_done, a_core_rdata, e.rdata); end
        a_core_req = 1'b0;
        tick();
        vectors++;
        if (a_core_done !== 1'b0 || a_busy !== 1'b0 || a_core_rdata !== 8'hA5 || a_mem_addr !== '0)
            begin miscompares++; $display("FAIL t1_after: done=%b busy=%b rdata=%h addr=%h want 0 0 a5 000", a_core_done, a_busy, a_core_rdata, a_mem_addr); end
    endtask

    task automatic test_host_write();
        exp_t e;
        a_host_we = 1'b1; a_host_addr = 12'hFFF; a_host_wdata = 8'h3C; a_host_req = 1'b1;
        tick();
        vectors++;
        if (a_mem_en !== 1'b1 || a_mem_we !== 1'b1 || a_mem_addr !== 12'hFFF || a_mem_wdata !== 8'h3C)
            begin miscompares++; $display("FAIL t2_issue: en=%b we=%b addr=%h wd=%h want 1 1 fff 3c", a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata); end
        tick();
        vectors++;
        if (a_host_done !== 1'b1 || a_core_done !== 1'b0 || a_host_rdata !== 8'h00)
            begin miscompares++; $display("FAIL t2_done: hdone=%b cdone=%b hrdata=%h want 1 0 00", a_host_done, a_core_done, a_host_rdata); end
        a_host_req = 1'b0;
        tick();
        vectors++;
        if (a_host_done !== 1'b0 || a_busy !== 1'b0 || a_mem_we !== 1'b0 || a_mem_wdata !== '0)
            begin miscompares++; $display("FAIL t2_after: done=%b busy=%b we=%b wd=%h want 0 0 0 00", a_host_done, a_busy, a_mem_we, a_mem_wdata); end
        a_host_we = 1'b0; a_host_req = 1'b1;
        sbq.push_back('{OWNER_HOST, 8'h3C});
        tick();
        vectors++;
        if (a_mem_en !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 12'hFFF)
            begin miscompares++; $display("FAIL t2_rb_issue: en=%b we=%b addr=%h want 1 0 fff", a_mem_en, a_mem_we, a_mem_addr); end
        tick();
        e = sbq.pop_front();
        vectors++;
        if (a_host_done !== 1'b1 || a_host_rdata !== e.rdata)
            begin miscompares++; $display("FAIL t2_readback: done=%b rdata=%h want 1 %h", a_host_done, a_host_rdata, e.rdata); end
        a_host_req = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        int  grants = 0;
        int  last   = -1;
        logic got, want;
        for (int i = 0; i < 10; i++) begin
`ifdef PAMPY_ARB_ROUND_ROBIN_EN
            ownq.push_back((i % 2 == 1) ? OWNER_HOST : OWNER_CORE);
`else
            ownq.push_back((i % 5 == 4) ? OWNER_HOST : OWNER_CORE);
`endif
        end
        a_core_we = 1'b0; a_core_addr = 12'h100;
        a_host_we = 1'b0; a_host_addr = 12'h200;
        a_core_req = 1'b1; a_host_req = 1'b1;
        for (int cyc = 0; cyc < 80 && grants < 10; cyc++) begin
            tick();
            if (a_mem_en) begin
                got  = (a_mem_addr == 12'h200) ? OWNER_HOST : OWNER_CORE;
                want = ownq.pop_front();
                vectors++;
                if (got !== want)
                    begin miscompares++; $display("FAIL t3_order[%0d]: owner=%b want %b", grants, got, want); end
                if (last >= 0) begin
                    vectors++;
                    if (cyc - last != 3)
                        begin miscompares++; $display("FAIL t3_spacing[%0d]: %0d cycles want 3", grants, cyc - last); end
                end
                last = cyc;
                grants++;
            end
        end
        vectors++;
        if (grants != 10)
            begin miscompares++; $display("FAIL t3_timeout: grants=%0d want 10", grants); end
        a_core_req = 1'b0; a_host_req = 1'b0;
        for (int k = 0; k < 10 && a_busy; k++) tick();
        vectors++;
        if (a_busy !== 1'b0)
            begin miscompares++; $display("FAIL t3_idle: busy=%b want 0", a_busy); end
    endtask

    task automatic test_read_latency();
        exp_t e;
        preload(1'b1, 12'h020, 8'h5A);
        preload(1'b1, 12'h021, 8'h77);
        b_core_we = 1'b0; b_core_addr = 12'h020; b_core_req = 1'b1;
        sbq.push_back('{OWNER_CORE, 8'h5A});
        tick();
        vectors++;
        if (b_mem_en !== 1'b1 || b_mem_addr !== 12'h020)
            begin miscompares++; $display("FAIL t4_issue: en=%b addr=%h want 1 020", b_mem_en, b_mem_addr); end
        b_host_we = 1'b0; b_host_addr = 12'h021; b_host_req = 1'b1;
        sbq.push_back('{OWNER_HOST, 8'h77});
        for (int w = 0; w < 2; w++) begin
            tick();
            vectors++;
            if (b_mem_en !== 1'b0 || b_busy !== 1'b1 || b_core_done !== 1'b0 || b_host_done !== 1'b0)
                begin miscompares++; $display("FAIL t4_wait%0d: en=%b busy=%b cdone=%b hdone=%b want 0 1 0 0", w, b_mem_en, b_busy, b_core_done, b_host_done); end
        end
        tick();
        e = sbq.pop_front();
        vectors++;
        if (b_core_done !== 1'b1 || b_host_done !== 1'b0 || b_core_rdata !== e.rdata)
            begin miscompares++; $display("FAIL t4_core_done: done=%b hdone=%b rdata=%h want 1 0 %h", b_core_done, b_host_done, b_core_rdata, e.rdata); end
        b_core_req = 1'b0;
        tick();
        vectors++;
        if (b_mem_en !== 1'b0 || b_host_done !== 1'b0 || b_busy !== 1'b0)
            begin miscompares++; $display("FAIL t4_idle: en=%b hdone=%b busy=%b want 0 0 0", b_mem_en, b_host_done, b_busy); end
        tick();
        vectors++;
        if (b_mem_en !== 1'b1 || b_mem_addr !== 12'h021)
            begin miscompares++; $display("FAIL t4_host_issue: en=%b addr=%h want 1 021", b_mem_en, b_mem_addr); end
        tick(); tick(); tick();
        e = sbq.pop_front();
        vectors++;
        if (b_host_done !== 1'b1 || b_host_rdata !== e.rdata)
            begin miscompares++; $display("FAIL t4_host_done: done=%b rdata=%h want 1 %h", b_host_done, b_host_rdata, e.rdata); end
        b_host_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        int   dones = 0;
        b_core_we = 1'b0; b_core_addr = 12'h020; b_core_req = 1'b1;
        tick();
        tick();
        vectors++;
        if (b_busy !== 1'b1 || b_mem_en !== 1'b0)
            begin miscompares++; $display("FAIL t5_in_wait: busy=%b en=%b want 1 0", b_busy, b_mem_en); end
        rst = 1'b1; b_core_req = 1'b0;
        #1;
        vectors++;
        if ({b_busy, b_mem_en, b_core_done, b_host_done} !== 4'b0 || b_core_rdata !== 8'h00)
            begin miscompares++; $display("FAIL t5_async: ctrl=%b rdata=%h want 0000 00", {b_busy, b_mem_en, b_core_done, b_host_done}, b_core_rdata); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (b_core_done || b_host_done || b_mem_en) dones++;
        end
        vectors++;
        if (dones != 0)
            begin miscompares++; $display("FAIL t5_no_done: %0d stray events want 0", dones); end
        b_core_req = 1'b1;
        sbq.push_back('{OWNER_CORE, 8'h5A});
        tick();
        vectors++;
        if (b_mem_en !== 1'b1 || b_mem_addr !== 12'h020)
            begin miscompares++; $display("FAIL t5_reissue: en=%b addr=%h want 1 020", b_mem_en, b_mem_addr); end
        tick(); tick(); tick();
        e = sbq.pop_front();
        vectors++;
        if (b_core_done !== 1'b1 || b_core_rdata !== e.rdata)
            begin miscompares++; $display("FAIL t5_done: done=%b rdata=%h want 1 %h", b_core_done, b_core_rdata, e.rdata); end
        b_core_req = 1'b0;
        tick();
    endtask

    task automatic test_addr_change();
        exp_t e;
        int   dones = 0;
        int   extra_en = 0;
        a_core_we = 1'b0; a_core_addr = 12'h010; a_core_req = 1'b1;
        sbq.push_back('{OWNER_CORE, 8'hA5});
        tick();
        a_core_addr = 12'h055; a_core_wdata = 8'hFF; a_core_we = 1'b1;
        #1;
        vectors++;
        if (a_mem_en !== 1'b1 || a_mem_addr !== 12'h010 || a_mem_we !== 1'b0)
            begin miscompares++; $display("FAIL t6_latched: en=%b addr=%h we=%b want 1 010 0", a_mem_en, a_mem_addr, a_mem_we); end
        for (int k = 0; k < 6; k++) begin
            tick();
            if (a_mem_en) extra_en++;
            if (a_core_done) begin
                dones++;
                e = sbq.pop_front();
                vectors++;
                if (a_core_rdata !== e.rdata)
                    begin miscompares++; $display("FAIL t6_rdata: got %h want %h", a_core_rdata, e.rdata); end
                a_core_req = 1'b0;
            end
        end
        vectors++;
        if (dones != 1 || extra_en != 0)
            begin miscompares++; $display("FAIL t6_once: dones=%0d extra_mem_en=%0d want 1 0", dones, extra_en); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        test_reset();
        test_core_read();
        test_host_write();
        test_fairness();
        test_read_latency();
        test_reset_in_wait();
        test_addr_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
